// File: rtl/reduction_adder_node.sv
// reduction_adder_node: registered adder placed after a reduction select mux.
// For each accepted beat the node does one of four things: adds the two
// operands, passes the left operand, passes the right operand, or accumulates
// across a multi-beat burst. Results go into a 2-entry output FIFO with
// valid/ready handshakes on both sides.
//
// Optional feature: define REDUCTION_ADDER_SAT_EN to saturate every add step
// to the signed min/max. Without it, results wrap modulo 2^W. o_ovf reports
// overflow in both builds.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : upstream beat valid
//   o_ready    : node can accept a beat (queue count < 2)
//   i_data     : [W-1:0] left operand, [2W-1:W] right operand
//   i_mode     : 00 add, 01 pass left, 10 pass right, 11 accumulate
//   i_last     : final beat of an accumulate burst (only used in mode 11)
//   o_valid    : result available at the queue head
//   i_ready    : downstream accepts the result
//   o_data     : result (head of queue)
//   o_ovf      : signed overflow occurred while producing this result
//   o_drop     : one-cycle pulse when a partial accumulation was discarded
module reduction_adder_node #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [2*W-1:0] i_data,
  input  logic [1:0]     i_mode,
  input  logic           i_last,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [W-1:0]   o_data,
  output logic           o_ovf,
  output logic           o_drop
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  localparam logic [1:0] MODE_ADD    = 2'b00;
  localparam logic [1:0] MODE_PASS_L = 2'b01;
  localparam logic [1:0] MODE_PASS_R = 2'b10;
  localparam logic [1:0] MODE_ACCUM  = 2'b11;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } entry_t;

  // One two-operand add step, with overflow flag and optional saturation.
  function automatic entry_t add_step(input logic [W-1:0] a, input logic [W-1:0] b);
    entry_t r;
    r.data = a + b;
    r.ovf  = (a[W-1] == b[W-1]) && (r.data[W-1] != a[W-1]);
`ifdef REDUCTION_ADDER_SAT_EN
    if (r.ovf) begin
      r.data = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    return r;
  endfunction

  state_e        state_q;
  logic [W-1:0]  acc_q;
  logic          acc_ovf_q;
  logic          drop_q;

  entry_t        mem_q [DEPTH];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [W-1:0]  left;
  logic [W-1:0]  right;
  logic [W-1:0]  acc_base;
  entry_t        add_res;
  entry_t        acc_step1;
  entry_t        acc_step2;
  logic          acc_ovf_sum;
  entry_t        push_entry;
  logic          accept;
  logic          push;
  logic          pop;

  assign left   = i_data[W-1:0];
  assign right  = i_data[2*W-1:W];

  assign o_ready = (count_q != CW'(DEPTH));
  assign o_valid = (count_q != '0);
  assign o_data  = mem_q[rd_ptr_q].data;
  assign o_ovf   = mem_q[rd_ptr_q].ovf;
  assign o_drop  = drop_q;

  assign accept = i_valid && o_ready;
  assign pop    = o_valid && i_ready;

  // Datapath: plain add plus the burst add, done as (base + left) + right.
  always_comb begin
    acc_base    = (state_q == ACCUM) ? acc_q : '0;
    add_res     = add_step(left, right);
    acc_step1   = add_step(acc_base, left);
    acc_step2   = add_step(acc_step1.data, right);
    // Overflow is sticky over the whole burst.
    acc_ovf_sum = acc_step1.ovf || acc_step2.ovf || ((state_q == ACCUM) && acc_ovf_q);

    push_entry = add_res;
    case (i_mode)
      MODE_ADD:    push_entry = add_res;
      MODE_PASS_L: push_entry = '{data: left,  ovf: 1'b0};
      MODE_PASS_R: push_entry = '{data: right, ovf: 1'b0};
      MODE_ACCUM:  push_entry = '{data: acc_step2.data, ovf: acc_ovf_sum};
      default:     push_entry = add_res;
    endcase

    // Only an intermediate accumulate beat produces no result.
    push = accept && !((i_mode == MODE_ACCUM) && !i_last);
  end

  // Burst FSM, accumulator and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (accept) begin
        if ((i_mode == MODE_ACCUM) && !i_last) begin
          state_q   <= ACCUM;
          acc_q     <= acc_step2.data;
          acc_ovf_q <= acc_ovf_sum;
        end else begin
          state_q   <= IDLE;
          acc_q     <= '0;
          acc_ovf_q <= 1'b0;
          // A non-accumulate beat in the middle of a burst discards the partial sum.
          drop_q    <= (i_mode != MODE_ACCUM) && (state_q == ACCUM);
        end
      end
    end
  end

  // 2-entry output FIFO; push and pop on the same edge keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_reduction_adder_node.sv
// Testbench for reduction_adder_node: directed scenarios plus randomized
// traffic. A reference model queues expected results, and a monitor compares
// every result the DUT hands over.
module tb_reduction_adder_node;

  localparam int unsigned W = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint MODV = 64'sd4294967296;

  logic           clk;
  logic           rst_n;
  logic           i_valid;
  logic           o_ready;
  logic [2*W-1:0] i_data;
  logic [1:0]     i_mode;
  logic           i_last;
  logic           o_valid;
  logic           i_ready;
  logic [W-1:0]   o_data;
  logic           o_ovf;
  logic           o_drop;

  reduction_adder_node #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_mode (i_mode),
    .i_last (i_last),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_ovf  (o_ovf),
    .o_drop (o_drop)
  );

  int tests = 0;
  int fails = 0;
  logic [W:0] exp_q[$];
  int exp_drops = 0;
  int seen_drops = 0;

  // Reference model state.
  bit     in_burst = 0;
  longint acc_m = 0;
  bit     acc_ovf_m = 0;

  bit   rand_ready = 0;
  logic rdy_fixed = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single driver for i_ready; it changes only 1 time unit after a rising edge.
  always @(posedge clk) begin
    #1 i_ready = rand_ready ? logic'($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // One signed add on mathematical integers, then wrap or saturate to 32 bits.
  function automatic void step(input longint a, input longint b, output longint r, output bit ov);
    longint s;
    s  = a + b;
    ov = (s > MAXV) || (s < MINV);
`ifdef REDUCTION_ADDER_SAT_EN
    r = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
`else
    if (s > MAXV) s = s - MODV;
    if (s < MINV) s = s + MODV;
    r = s;
`endif
  endfunction

  function automatic void model_beat(input logic [31:0] l, input logic [31:0] r,
                                     input logic [1:0] m, input logic last);
    longint a, b, t1, t2, base;
    bit o1, o2, ov;
    a = longint'($signed(l));
    b = longint'($signed(r));
    if (m == 2'b11) begin
      base = in_burst ? acc_m : 0;
      step(base, a, t1, o1);
      step(t1, b, t2, o2);
      ov = o1 || o2 || (in_burst && acc_ovf_m);
      if (last) begin
        exp_q.push_back({32'(t2), ov});
        in_burst = 0; acc_m = 0; acc_ovf_m = 0;
      end else begin
        in_burst = 1; acc_m = t2; acc_ovf_m = ov;
      end
    end else begin
      if (in_burst) exp_drops++;
      in_burst = 0; acc_m = 0; acc_ovf_m = 0;
      if (m == 2'b00) begin
        step(a, b, t1, o1);
        exp_q.push_back({32'(t1), o1});
      end else if (m == 2'b01) begin
        exp_q.push_back({l, 1'b0});
      end else begin
        exp_q.push_back({r, 1'b0});
      end
    end
  endfunction

  // Monitor: compare every handed-over result against the scoreboard.
  logic [W:0] mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_drop) seen_drops++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h expected no output", o_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_data", o_data, mon_e[W:1]);
          check("result_ovf", 32'(o_ovf), 32'(mon_e[0]));
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat starting at posedge+1 and return 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [1:0] m, input logic last);
    bit rdy;
    bit ok;
    int n;
    n = 0;
    ok = 0;
    i_valid = 1'b1;
    i_data  = {r, l};
    i_mode  = m;
    i_last  = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      rdy = o_ready;
      @(posedge clk);
      if (rdy) ok = 1;
      n++;
    end
    if (ok) begin
      model_beat(l, r, m, last);
    end else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 200 cycles");
    end
    #1 i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !o_valid;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lv, rv;
    logic [1:0]  mv;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_mode  = 2'b00;
    i_last  = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_data", o_data, 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    check("rst_drop", 32'(o_drop), 32'd0);

    // Simple add, 1-cycle latency
    sync();
    send(32'd5, 32'd7, 2'b00, 1'b0);
    @(negedge clk);
    check("add_latency_valid", 32'(o_valid), 32'd1);
    check("add_data", o_data, 32'd12);
    @(negedge clk);
    check("add_queue_empty", 32'(o_valid), 32'd0);

    // Backpressure: two beats fill the queue, the third is held
    rdy_fixed = 1'b0;
    sync(); sync();
    send(32'd1, 32'd1, 2'b00, 1'b0);
    send(32'd2, 32'd2, 2'b00, 1'b0);
    @(negedge clk);
    check("bp_ready_low", 32'(o_ready), 32'd0);
    check("bp_head_hold", o_data, 32'd2);
    sync();
    fork
      send(32'd3, 32'd3, 2'b00, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_ready_held", 32'(o_ready), 32'd0);
        end
        rdy_fixed = 1'b1;
      end
    join
    drain("bp_drain");

    // Back-to-back beats with i_ready high: push and pop on the same edge at count=1
    sync();
    send(32'd10, 32'd1, 2'b00, 1'b0);
    send(32'd20, 32'd2, 2'b01, 1'b0);
    send(32'd30, 32'd3, 2'b10, 1'b0);
    send(32'd40, 32'd4, 2'b00, 1'b0);
    @(negedge clk);
    check("pp_valid", 32'(o_valid), 32'd1);
    check("pp_ready", 32'(o_ready), 32'd1);
    drain("pp_drain");

    // Accumulate burst
    sync();
    send(32'd1, 32'd2, 2'b11, 1'b0);
    @(negedge clk);
    check("acc_no_out1", 32'(o_valid), 32'd0);
    sync();
    send(32'd3, 32'd4, 2'b11, 1'b0);
    @(negedge clk);
    check("acc_no_out2", 32'(o_valid), 32'd0);
    sync();
    send(32'd10, 32'd20, 2'b11, 1'b1);
    @(negedge clk);
    check("acc_valid", 32'(o_valid), 32'd1);
    check("acc_data", o_data, 32'd40);
    drain("acc_drain");

    // Overflow boundaries
    sync();
    send(32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0);
    @(negedge clk);
`ifdef REDUCTION_ADDER_SAT_EN
    check("ovf_pos_data", o_data, 32'h7FFF_FFFF);
`else
    check("ovf_pos_data", o_data, 32'h8000_0000);
`endif
    check("ovf_pos_flag", 32'(o_ovf), 32'd1);
    sync();
    send(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0);
    @(negedge clk);
`ifdef REDUCTION_ADDER_SAT_EN
    check("ovf_neg_data", o_data, 32'h8000_0000);
`else
    check("ovf_neg_data", o_data, 32'h7FFF_FFFF);
`endif
    check("ovf_neg_flag", 32'(o_ovf), 32'd1);
    drain("ovf_drain");

    // Abort a burst with a pass-left beat
    sync();
    send(32'd5, 32'd5, 2'b11, 1'b0);
    sync();
    send(32'd9, 32'd4, 2'b01, 1'b0);
    @(negedge clk);
    check("abort_drop", 32'(o_drop), 32'd1);
    check("abort_data", o_data, 32'd9);
    @(negedge clk);
    check("abort_drop_pulse", 32'(o_drop), 32'd0);
    sync();
    send(32'd1, 32'd1, 2'b11, 1'b1);
    @(negedge clk);
    check("abort_acc_cleared", o_data, 32'd2);
    drain("abort_drain");

    // Reset while a result is queued and a burst is in progress
    rdy_fixed = 1'b0;
    sync(); sync();
    send(32'd7, 32'd8, 2'b00, 1'b0);
    sync();
    send(32'd2, 32'd2, 2'b11, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(o_valid), 32'd0);
    exp_q.delete();
    in_burst = 0; acc_m = 0; acc_ovf_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_fixed = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", 32'(o_ready), 32'd1);
    check("rst_rel_valid", 32'(o_valid), 32'd0);
    sync(); sync();
    send(32'd3, 32'd3, 2'b11, 1'b1);
    @(negedge clk);
    check("rst_rel_acc", o_data, 32'd6);
    drain("rst_drain");

    // Randomized traffic with random backpressure
    rand_ready = 1;
    sync();
    for (int k = 0; k < 300; k++) begin
      mv = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        lv = $urandom();
        rv = $urandom();
      end else begin
        lv = 32'($urandom_range(0, 2000)) - 32'd1000;
        rv = 32'($urandom_range(0, 2000)) - 32'd1000;
      end
      send(lv, rv, mv, logic'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 4) == 0) sync();
    end
    rand_ready = 0;
    rdy_fixed = 1'b1;
    drain("rand_drain");
    check("drop_count", 32'(seen_drops), 32'(exp_drops));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
